// File: rtl/fsmd_arbiter.sv
`timescale 1ns/1ps
// Round-robin job scheduler sharing one fsmd datapath between NREQ requesters.
// Operands are fed on datapath ready pulses; the result is returned to the grantee.
module fsmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int NOPS    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [NREQ-1:0]        req_valid_in,
  output logic [NREQ-1:0]        req_ready_out,
  input  logic [NREQ*NOPS*16-1:0] req_ops_in,
  output logic [NREQ-1:0]        rsp_valid_out,
  input  logic [NREQ-1:0]        rsp_ready_in,
  output logic [15:0]            rsp_data_out,
  output logic                   rsp_err_out,
  output logic                   fsmd_srst_out,
  output logic [15:0]            fsmd_ext_in_out,
  input  logic                   fsmd_ready_in,
  input  logic                   fsmd_done_in,
  input  logic [15:0]            fsmd_ext_out_in
);

  localparam int GW = $clog2(NREQ);
  localparam int IW = $clog2(NOPS) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int OW = NOPS * 16;

  localparam logic [IW-1:0]   IDX_LAST = IW'(NOPS - 1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 2);
  localparam logic [GW-1:0]   GNT_LAST = GW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q, err_d;
  logic [15:0]     data_q, data_d;
  logic [OW-1:0]   ops_q, ops_d;

  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic            found;
  logic            tmo;

  // First valid requester at or after ptr, wrapping.
  always_comb begin : arb
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign tmo = (tmr_q == TMR_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin : nxt
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    data_d  = data_q;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          gnt_d   = win;
          ptr_d   = (win == GNT_LAST) ? '0 : win + 1'b1;
          ops_d   = req_ops_in[int'(win)*OW +: OW];
          idx_d   = '0;
          tmr_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD, RUN: begin
        tmr_d = tmr_q + 1'b1;
        // done outranks a same-edge ready and the timeout
        if (fsmd_done_in) begin
          data_d  = fsmd_ext_out_in;
          state_d = RESP;
          if (state_q == LOAD) err_d = 1'b1;
        end else if (tmo) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (fsmd_ready_in) begin
          if (state_q == RUN) begin
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = RUN;
          end
        end
      end
      RESP: begin
        if (rsp_ready_in[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outs
    req_ready_out   = '0;
    rsp_valid_out   = '0;
    rsp_data_out    = '0;
    rsp_err_out     = 1'b0;
    fsmd_srst_out   = 1'b1;
    fsmd_ext_in_out = '0;
    unique case (state_q)
      IDLE: begin
        if (found) req_ready_out = ONE << win;
      end
      LOAD: begin
        fsmd_srst_out   = 1'b0;
        fsmd_ext_in_out = ops_q[int'(idx_q)*16 +: 16];
      end
      RUN: begin
        fsmd_srst_out = 1'b0;
      end
      RESP: begin
        rsp_valid_out = ONE << gnt_q;
        rsp_data_out  = data_q;
        rsp_err_out   = err_q;
      end
      default: begin
        fsmd_srst_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fsmd_arbiter.sv
`timescale 1ns/1ps
// Bench for fsmd_arbiter: stub datapath plus a job-level scoreboard
// predicting grants, operand feed, response timing and result.
module tb_fsmd_arbiter;

  localparam int NREQ    = 2;
  localparam int NOPS    = 2;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [NREQ-1:0] req_valid_in = '0;
  logic [NREQ-1:0] req_ready_out;
  logic [NREQ*NOPS*16-1:0] req_ops_in;
  logic [NREQ-1:0] rsp_valid_out;
  logic [NREQ-1:0] rsp_ready_in = '0;
  logic [15:0] rsp_data_out;
  logic rsp_err_out;
  logic fsmd_srst_out;
  logic [15:0] fsmd_ext_in_out;
  logic fsmd_ready_in;
  logic fsmd_done_in;
  logic [15:0] fsmd_ext_out_in;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fsmd_arbiter #(
    .NREQ(NREQ),
    .NOPS(NOPS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_ops_in(req_ops_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out),
    .rsp_err_out(rsp_err_out),
    .fsmd_srst_out(fsmd_srst_out),
    .fsmd_ext_in_out(fsmd_ext_in_out),
    .fsmd_ready_in(fsmd_ready_in),
    .fsmd_done_in(fsmd_done_in),
    .fsmd_ext_out_in(fsmd_ext_out_in)
  );

  // stub datapath: nrdy ready pulses 2 cycles apart, done 5 after the last
  int nrdy = 2;
  bit done_en = 1'b1;
  int scyc = 0;
  logic [15:0] ssum = '0;

  always_ff @(posedge clk) begin
    if (fsmd_srst_out) begin
      scyc <= 0;
      ssum <= '0;
    end else begin
      scyc <= scyc + 1;
      if (fsmd_ready_in) ssum <= ssum + fsmd_ext_in_out;
    end
  end

  assign fsmd_ready_in = !fsmd_srst_out && (scyc % 2 == 1) && (scyc < 2*nrdy);
  assign fsmd_done_in = !fsmd_srst_out && done_en && (scyc == 2*nrdy + 4);
  assign fsmd_ext_out_in = ssum;

  logic [15:0] ops [NREQ][NOPS];

  always_comb begin
    req_ops_in = '0;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < NOPS; k++)
        req_ops_in[(i*NOPS+k)*16 +: 16] = ops[i][k];
  end

  // stimulus controls
  bit offer_en = 0, drop_en = 0, cont = 0, rnd_cfg = 0;
  int rmode = 0;

  // scoreboard state
  int t = 0;
  bit in_job = 0;
  int g = 0, t_acc = 0, lat = 0, k_op = 0, ptr_m = 0;
  logic [15:0] jops [NOPS];
  logic [15:0] exp_data;
  bit exp_err;
  logic [NREQ-1:0] acc_prev = '0;
  int gq[$];
  int nrsp = 0, last_rsp_t = 0, last_rsp_g = -1, last_grant_t = 0;
  int last_grant_g = -1, obs_lat = 0;
  bit seen_rsp = 0;
  logic [15:0] last_data = '0;
  logic last_err = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int winner(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p+i)%NREQ]) return (p+i)%NREQ;
    return -1;
  endfunction

  task automatic new_ops(int i);
    for (int k = 0; k < NOPS; k++) ops[i][k] = 16'($urandom);
  endtask

  task automatic drive();
    if (rnd_cfg && !in_job) begin
      nrdy = $urandom_range(1, 3);
      done_en = ($urandom_range(0, 7) != 0);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid_in[i] && acc_prev[i]) begin
        req_valid_in[i] = cont;
        if (cont) new_ops(i);
      end else if (!req_valid_in[i] &&
                   (cont || (offer_en && $urandom_range(0, 3) == 0))) begin
        req_valid_in[i] = 1'b1;
        new_ops(i);
      end else if (req_valid_in[i] && drop_en && $urandom_range(0, 15) == 0) begin
        req_valid_in[i] = 1'b0;
      end
    end
    case (rmode)
      0: rsp_ready_in = '1;
      1: rsp_ready_in = NREQ'($urandom);
      default: rsp_ready_in = '0;
    endcase
  endtask

  task automatic start_job(int w);
    in_job = 1;
    g = w;
    ptr_m = (w + 1) % NREQ;
    t_acc = t;
    k_op = 0;
    seen_rsp = 0;
    gq.push_back(w);
    last_grant_t = t;
    last_grant_g = w;
    exp_data = '0;
    for (int k = 0; k < NOPS; k++) begin
      jops[k] = ops[w][k];
      if (k < nrdy) exp_data = exp_data + jops[k];
    end
    exp_err = (nrdy != NOPS);
    lat = 2*nrdy + 6;
    if (!done_en || lat > TIMEOUT) begin
      lat = TIMEOUT;
      exp_data = '0;
      exp_err = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int w;
    t++;
    acc_prev = req_ready_out & req_valid_in;
    if (in_job && !seen_rsp && rsp_valid_out != '0) begin
      seen_rsp = 1;
      obs_lat = t - t_acc;
    end
    if (!in_job) begin
      w = winner(req_valid_in, ptr_m);
      chk("grant", req_ready_out, (w < 0) ? 0 : (1 << w));
      chk("idle_rsp", rsp_valid_out, 0);
      chk("idle_out", {rsp_err_out, rsp_data_out}, 0);
      chk("idle_srst", fsmd_srst_out, 1);
      if (w >= 0) start_job(w);
    end else if (t < t_acc + lat) begin
      chk("busy_grant", req_ready_out, 0);
      chk("busy_rsp", rsp_valid_out, 0);
      chk("busy_srst", fsmd_srst_out, 0);
      if (fsmd_ready_in && !fsmd_done_in) begin
        chk("operand", fsmd_ext_in_out, (k_op < NOPS) ? jops[k_op] : 16'd0);
        k_op++;
      end
    end else begin
      chk("rsp_valid", rsp_valid_out, 1 << g);
      chk("rsp_data", rsp_data_out, exp_data);
      chk("rsp_err", rsp_err_out, exp_err);
      chk("rsp_srst", fsmd_srst_out, 1);
      chk("rsp_grant", req_ready_out, 0);
      if (rsp_ready_in[g]) begin
        in_job = 0;
        nrsp++;
        last_rsp_t = t;
        last_rsp_g = g;
        last_data = rsp_data_out;
        last_err = rsp_err_out;
      end
    end
  endtask

  // called at a falling edge, returns at the next one
  task automatic step();
    drive();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic run_until_rsp(string tag, int bound);
    int n0;
    n0 = nrsp;
    for (int n = 0; n < bound && nrsp == n0; n++) step();
    chk({tag, "_to"}, (nrsp != n0), 1);
  endtask

  task automatic drain();
    offer_en = 0;
    drop_en = 0;
    cont = 0;
    rnd_cfg = 0;
    rmode = 0;
    for (int n = 0; n < 300 && (in_job || req_valid_in != '0); n++) step();
    chk("drain_to", (in_job || req_valid_in != '0), 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_rdy"}, req_ready_out, 0);
    chk({tag, "_rsp"}, rsp_valid_out, 0);
    chk({tag, "_out"}, {rsp_err_out, rsp_data_out}, 0);
    chk({tag, "_srst"}, fsmd_srst_out, 1);
    chk({tag, "_ext"}, fsmd_ext_in_out, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < NOPS; k++) ops[i][k] = '0;
    #1;
    chk_reset_outs("rst0");
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // single job
    ops[0][0] = 16'd7;
    ops[0][1] = 16'd9;
    req_valid_in = 2'b01;
    run_until_rsp("single", 40);
    chk("single_g", last_rsp_g, 0);
    chk("single_data", last_data, 16);
    chk("single_err", last_err, 0);
    chk("single_lat", obs_lat, 10);
    drain();

    // round robin, both always requesting
    gq.delete();
    cont = 1;
    repeat (60) step();
    drain();
    chk("rr_njobs", (gq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk("rr_order", gq[i], (1 + i) % 2);

    // randomized traffic
    offer_en = 1;
    drop_en = 1;
    rnd_cfg = 1;
    rmode = 1;
    repeat (600) step();
    drain();

    // timeout
    nrdy = 2;
    done_en = 0;
    ops[1][0] = 16'h1111;
    ops[1][1] = 16'h2222;
    req_valid_in = 2'b10;
    run_until_rsp("tmo", 60);
    chk("tmo_lat", obs_lat, TIMEOUT);
    chk("tmo_data", last_data, 0);
    chk("tmo_err", last_err, 1);
    drain();
    done_en = 1;

    // early done after one operand
    nrdy = 1;
    ops[0][0] = 16'd100;
    ops[0][1] = 16'd200;
    req_valid_in = 2'b01;
    run_until_rsp("early", 40);
    chk("early_data", last_data, 100);
    chk("early_err", last_err, 1);
    drain();

    // datapath asks for a third operand
    nrdy = 3;
    ops[1][0] = 16'd300;
    ops[1][1] = 16'd45;
    req_valid_in = 2'b10;
    run_until_rsp("extra", 40);
    chk("extra_data", last_data, 345);
    chk("extra_err", last_err, 1);
    chk("extra_ops", k_op, 3);
    drain();
    nrdy = 2;

    // backpressure
    rmode = 2;
    ops[0][0] = 16'd40;
    ops[0][1] = 16'd2;
    ops[1][0] = 16'd5;
    ops[1][1] = 16'd6;
    req_valid_in = 2'b11;
    for (int n = 0; n < 40 && rsp_valid_out == '0; n++) step();
    chk("bp_to", (rsp_valid_out != '0), 1);
    begin
      logic [15:0] hd;
      logic [NREQ-1:0] hv;
      int g0;
      hd = rsp_data_out;
      hv = rsp_valid_out;
      g0 = gq.size();
      repeat (10) step();
      chk("bp_data", rsp_data_out, hd);
      chk("bp_valid", rsp_valid_out, hv);
      chk("bp_nogrant", gq.size(), g0);
    end
    rmode = 0;
    step();
    step();
    chk("bp_regrant", last_grant_t - last_rsp_t, 1);
    drain();

    // async reset in the middle of a job
    ops[0][0] = 16'd11;
    ops[0][1] = 16'd22;
    req_valid_in = 2'b01;
    for (int n = 0; n < 20 && !(in_job && t >= t_acc + 5); n++) step();
    chk("mid_to", (in_job && t >= t_acc + 5), 1);
    chk("mid_busy", fsmd_srst_out, 0);
    req_valid_in = '0;
    #3;
    arst_n = 1'b0;
    #1;
    chk_reset_outs("rst1");
    in_job = 0;
    ptr_m = 0;
    acc_prev = '0;
    @(negedge clk);
    chk_reset_outs("rst2");
    arst_n = 1'b1;
    ops[0][0] = 16'd1;
    ops[0][1] = 16'd2;
    ops[1][0] = 16'd1000;
    ops[1][1] = 16'd234;
    req_valid_in = 2'b11;
    step();
    chk("rst_ptr", last_grant_g, 0);
    run_until_rsp("post0", 40);
    chk("post0_data", last_data, 3);
    run_until_rsp("post1", 40);
    chk("post1_g", last_rsp_g, 1);
    chk("post1_data", last_data, 1234);
    chk("post1_err", last_err, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
